demux8_rr_dispatch: RTL and testbench

Round-robin dispatcher that sequences the 1-to-8 demultiplexer: it accepts a single input word stream and steers each word to exactly one of eight output channels. Channel choice rotates over a runtime enable mask. A one-entry output register with valid/ready handshakes on both sides sits between the upstream producer and the eight downstream consumers.

---
 rtl/demux8_rr_dispatch_if.sv | 25 ++
 rtl/demux8_rr_dispatch.sv | 99 +++++++++
 tb/tb_demux8_rr_dispatch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/demux8_rr_dispatch_if.sv
// Handshake bundle between one upstream producer, the dispatcher and eight consumers.
// The dispatcher uses the slave modport; the producer/consumer side uses master.
interface demux8_rr_dispatch_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [7:0]    ch_mask;
  logic [7:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    out_sel;
  logic [7:0]    out_ready;
  logic [15:0]   xfer_cnt;

  modport master (
    output in_valid, in_data, ch_mask, out_ready,
    input  in_ready, out_valid, out_data, out_sel, xfer_cnt
  );

  modport slave (
    input  in_valid, in_data, ch_mask, out_ready,
    output in_ready, out_valid, out_data, out_sel, xfer_cnt
  );
endinterface

// File: rtl/demux8_rr_dispatch.sv
// Round-robin 1-to-8 dispatcher with a one-entry output register; one word per cycle
// when the addressed consumer is ready. in_ready is combinational, all outputs are registered.
module demux8_rr_dispatch #(
  parameter int DW = 8
) (
  input logic                  clk,
  input logic                  rst,
  demux8_rr_dispatch_if.slave  bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state, state_n;
  logic [DW-1:0] data_q, data_n;
  logic [2:0]    sel_q, sel_n;
  logic [2:0]    ptr, ptr_n;
  logic [15:0]   cnt, cnt_n;

  logic [15:0]   rot2;
  logic [7:0]    rot;
  logic [2:0]    idx;
  logic [2:0]    nxt;
  logic          in_rdy;
  logic          in_x;
  logic          out_x;

  // Rotate the mask so bit 0 is the pointer position, take the lowest set bit,
  // then translate back by adding the pointer (3-bit arithmetic wraps mod 8).
  always_comb begin
    rot2 = {bus.ch_mask, bus.ch_mask} >> ptr;
    rot  = rot2[7:0];
    idx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) idx = 3'(i);
    end
    nxt = ptr + idx;
  end

  always_comb begin
    in_rdy = !rst && (bus.ch_mask != 8'd0) &&
             ((state == EMPTY) || bus.out_ready[sel_q]);
    out_x  = (state == FULL) && bus.out_ready[sel_q];
    in_x   = bus.in_valid && in_rdy;
  end

  always_comb begin
    state_n = state;
    data_n  = data_q;
    sel_n   = sel_q;
    ptr_n   = ptr;
    cnt_n   = cnt;
    if (out_x) cnt_n = cnt + 16'd1;
    case (state)
      EMPTY: begin
        if (in_x) begin
          data_n  = bus.in_data;
          sel_n   = nxt;
          ptr_n   = nxt + 3'd1;
          state_n = FULL;
        end
      end
      FULL: begin
        // A simultaneous drain and load keeps the register full for back-to-back flow.
        if (in_x) begin
          data_n  = bus.in_data;
          sel_n   = nxt;
          ptr_n   = nxt + 3'd1;
          state_n = FULL;
        end else if (out_x) begin
          state_n = EMPTY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      data_q <= '0;
      sel_q  <= 3'd0;
      ptr    <= 3'd0;
      cnt    <= 16'd0;
    end else begin
      state  <= state_n;
      data_q <= data_n;
      sel_q  <= sel_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state == FULL) ? (8'd1 << sel_q) : 8'd0;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.xfer_cnt  = cnt;

endmodule

// File: tb/tb_demux8_rr_dispatch.sv
// Randomised and directed bench for demux8_rr_dispatch against a cycle-level reference model.
module tb_demux8_rr_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux8_rr_dispatch_if #(.DW(8)) ifc ();

  demux8_rr_dispatch #(.DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit       m_full;
  bit [7:0] m_data;
  int       m_sel;
  int       m_ptr;
  int       m_cnt;
  int       acc_sels[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare everything against the model, advance the model.
  task automatic step(input bit r, input bit v, input bit [7:0] d,
                      input bit [7:0] m, input bit [7:0] ordy);
    bit exp_rdy, in_x, out_x;
    int nxt;
    @(negedge clk);
    rst           = r;
    ifc.in_valid  = v;
    ifc.in_data   = d;
    ifc.ch_mask   = m;
    ifc.out_ready = ordy;
    #1;
    exp_rdy = !r && (m != 0) && (!m_full || ordy[m_sel]);
    chk("in_ready",  32'(ifc.in_ready),  32'(exp_rdy));
    chk("out_valid", 32'(ifc.out_valid), m_full ? (32'd1 << m_sel) : 32'd0);
    chk("out_data",  32'(ifc.out_data),  32'(m_data));
    chk("out_sel",   32'(ifc.out_sel),   32'(m_sel));
    chk("xfer_cnt",  32'(ifc.xfer_cnt),  32'(m_cnt));
    nxt = 0;
    for (int k = 7; k >= 0; k--) begin
      if (m[(m_ptr + k) % 8]) nxt = (m_ptr + k) % 8;
    end
    out_x = m_full && ordy[m_sel];
    in_x  = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (out_x) m_cnt = (m_cnt + 1) % 65536;
      if (in_x) begin
        m_data = d; m_sel = nxt; m_ptr = (nxt + 1) % 8; m_full = 1;
        acc_sels.push_back(nxt);
      end else if (out_x) begin
        m_full = 0;
      end
    end
  endtask

  initial begin
    int sparse_exp[5];
    sparse_exp = '{0, 4, 7, 0, 4};
    m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    ifc.in_valid = 0; ifc.in_data = 0; ifc.ch_mask = 8'hFF; ifc.out_ready = 0;

    // reset and idle
    step(1, 0, 8'h00, 8'hFF, 8'hFF);
    step(1, 0, 8'h00, 8'hFF, 8'hFF);
    #1;
    chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_out_sel",   32'(ifc.out_sel),   32'h0);
    chk("rst_xfer_cnt",  32'(ifc.xfer_cnt),  32'h0);
    step(0, 0, 8'h00, 8'hFF, 8'hFF);

    // full rotation
    acc_sels.delete();
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h10 + i), 8'hFF, 8'hFF);
    step(0, 0, 8'h00, 8'hFF, 8'hFF);
    #1;
    chk("rot_xfer_cnt", 32'(ifc.xfer_cnt), 32'd8);
    for (int i = 0; i < 8; i++) chk("rot_sel", 32'(acc_sels[i]), 32'(i));

    // sparse mask with wrap
    acc_sels.delete();
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h40 + i), 8'h91, 8'hFF);
    step(0, 0, 8'h00, 8'h91, 8'hFF);
    for (int i = 0; i < 5; i++) chk("sparse_sel", 32'(acc_sels[i]), 32'(sparse_exp[i]));

    // backpressure hold on ch 2
    step(0, 1, 8'hA5, 8'h04, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h5A, 8'hFF, 8'h00);
      #1;
      chk("hold_out_valid", 32'(ifc.out_valid), 32'h04);
      chk("hold_out_data",  32'(ifc.out_data),  32'hA5);
    end
    step(0, 0, 8'h00, 8'hFF, 8'hFF);
    acc_sels.delete();
    step(0, 1, 8'h3C, 8'hFF, 8'hFF);
    chk("after_hold_sel", 32'(acc_sels[0]), 32'd3);
    step(0, 0, 8'h00, 8'hFF, 8'hFF);

    // mask change while full: held word stays on ch 5
    step(0, 1, 8'h55, 8'h20, 8'h00);
    step(0, 1, 8'h66, 8'h02, 8'h00);
    step(0, 1, 8'h66, 8'h02, 8'h00);
    #1;
    chk("mask_hold_valid", 32'(ifc.out_valid), 32'h20);
    step(0, 0, 8'h00, 8'h02, 8'h20);
    acc_sels.delete();
    step(0, 1, 8'h77, 8'h02, 8'h00);
    chk("mask_next_sel", 32'(acc_sels[0]), 32'd1);
    step(0, 1, 8'h88, 8'h00, 8'hFF);
    step(0, 1, 8'h99, 8'h00, 8'hFF);
    #1;
    chk("mask0_empty", 32'(ifc.out_valid), 32'h0);

    // reset mid-stream
    step(0, 1, 8'hC3, 8'hFF, 8'h00);
    step(1, 1, 8'hC4, 8'hFF, 8'h00);
    #1;
    chk("mid_rst_valid", 32'(ifc.out_valid), 32'h0);
    chk("mid_rst_cnt",   32'(ifc.xfer_cnt),  32'h0);
    acc_sels.delete();
    step(0, 1, 8'hD1, 8'hFF, 8'hFF);
    chk("mid_rst_next_sel", 32'(acc_sels[0]), 32'd0);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit [7:0] m;
      m = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 1)) : 8'($urandom);
      step(($urandom_range(0, 199) == 0), 1'($urandom), 8'($urandom), m,
           ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
